// File: rtl/gray_decode.sv
// gray_decode: resynchronise a Gray stream, decode it to binary and buffer it in a 2-entry valid/ready FIFO.
// Optional step checker built when GRAY_DECODE_STEP_CHECK_EN is defined.
module gray_decode #(
  parameter int CODE_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CODE_WIDTH-1:0] gray_code,
  input  logic                  gray_code_valid,
  output logic [CODE_WIDTH-1:0] binary_code,
  output logic                  binary_code_valid,
  input  logic                  binary_code_ready,
  output logic                  step_error,
  output logic [7:0]            err_count,
  output logic                  overflow
);
  logic [CODE_WIDTH-1:0] s_code, dec, dec_q, tail;
  logic                  s_valid, push, pop;
  logic [1:0]            cnt;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign s_code  = gray_code;
      assign s_valid = gray_code_valid;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CODE_WIDTH-1:0] code_q;
      logic [SYNC_STAGES-1:0]                 valid_q;
      always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
          code_q  <= '0;
          valid_q <= '0;
        end else begin
          code_q[0]  <= gray_code;
          valid_q[0] <= gray_code_valid;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            code_q[i]  <= code_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      assign s_code  = code_q[SYNC_STAGES-1];
      assign s_valid = valid_q[SYNC_STAGES-1];
    end
  endgenerate

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < CODE_WIDTH; i++) dec[i] = ^(s_code >> i);
  end

  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      dec_q <= '0;
      push  <= 1'b0;
    end else begin
      push <= s_valid;
      if (s_valid) dec_q <= dec;
    end

  assign binary_code_valid = cnt != 2'd0;
  assign pop               = binary_code_valid && binary_code_ready;

  // binary_code is the head slot itself; tail holds the second word when full.
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      binary_code <= '0;
      tail        <= '0;
      cnt         <= 2'd0;
      overflow    <= 1'b0;
    end else begin
      if (push && cnt == 2'd2 && !pop) overflow <= 1'b1;
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) binary_code <= dec_q;
      else if (pop && cnt == 2'd2) binary_code <= tail;
      if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop))) tail <= dec_q;
      if (push && !pop && cnt != 2'd2) cnt <= cnt + 2'd1;
      else if (pop && !push) cnt <= cnt - 2'd1;
    end

`ifdef GRAY_DECODE_STEP_CHECK_EN
  typedef enum logic {IDLE, TRACK} state_t;
  state_t                state, state_n;
  logic [CODE_WIDTH-1:0] prev;
  logic                  bad;

  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      state      <= IDLE;
      prev       <= '0;
      step_error <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      state      <= state_n;
      step_error <= bad;
      if (s_valid) prev <= s_code;
      if (bad && err_count != 8'hff) err_count <= err_count + 8'd1;
    end

  always_comb begin
    state_n = s_valid ? TRACK : state;
    bad     = s_valid && state == TRACK && $countones(s_code ^ prev) > 1;
  end
`else
  assign step_error = 1'b0;
  assign err_count  = 8'd0;
`endif
endmodule

// File: tb/tb_gray_decode.sv
// tb_gray_decode: directed and random stimulus against a transaction-level queue model of gray_decode.
module tb_gray_decode;
  localparam int S = 2;
`ifdef GRAY_DECODE_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0, rstn = 1'b1;
  logic [3:0] gray_code = '0, binary_code;
  logic       gray_code_valid = 1'b0, binary_code_valid, binary_code_ready = 1'b0;
  logic       step_error, overflow;
  logic [7:0] err_count;

  gray_decode #(.CODE_WIDTH(4), .SYNC_STAGES(S)) dut (
    .clk(clk), .rstn(rstn), .gray_code(gray_code), .gray_code_valid(gray_code_valid),
    .binary_code(binary_code), .binary_code_valid(binary_code_valid),
    .binary_code_ready(binary_code_ready), .step_error(step_error),
    .err_count(err_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {int t_err; int t_push; bit err; logic [3:0] bin;} ev_t;
  ev_t        pend[$];
  logic [3:0] q[$];
  logic [3:0] prev;
  bit         ovf, tracking, exp_err;
  int         ecnt, cyc, tests, fails;

  function automatic logic [3:0] gray(input int n);
    return 4'(n ^ (n >> 1));
  endfunction

  function automatic logic [3:0] ungray(input logic [3:0] g);
    for (int n = 0; n < 16; n++) if (gray(n) == g) return 4'(n);
    return 4'hx;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    q.delete();
    ovf = 0;
    tracking = 0;
    exp_err = 0;
    ecnt = 0;
    prev = '0;
  endtask

  task automatic check_zero();
    check("rst_code", binary_code, 0);
    check("rst_valid", binary_code_valid, 0);
    check("rst_step_error", step_error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_overflow", overflow, 0);
  endtask

  task automatic cycle(input bit v, input logic [3:0] g, input bit rdy);
    bit pop;
    gray_code = g;
    gray_code_valid = v;
    binary_code_ready = rdy;
    @(posedge clk);
    cyc++;
    pop = rdy && q.size() > 0;
    if (pop) void'(q.pop_front());
    exp_err = 0;
    foreach (pend[i]) begin
      if (pend[i].t_err == cyc && pend[i].err) begin
        exp_err = 1;
        if (ecnt < 255) ecnt++;
      end
      if (pend[i].t_push == cyc) begin
        if (q.size() < 2) q.push_back(pend[i].bin);
        else ovf = 1;
      end
    end
    while (pend.size() > 0 && pend[0].t_push <= cyc) void'(pend.pop_front());
    if (v) begin
      ev_t e;
      e.err = CHK && tracking && $countones(g ^ prev) > 1;
      e.bin = ungray(g);
      e.t_err = cyc + S;
      e.t_push = cyc + S + 1;
      prev = g;
      tracking = 1;
      pend.push_back(e);
    end
    #1;
    check("valid", binary_code_valid, q.size() > 0);
    if (q.size() > 0) check("data", binary_code, q[0]);
    check("step_error", step_error, exp_err);
    check("err_count", err_count, ecnt);
    check("overflow", overflow, ovf);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, rdy);
  endtask

  initial begin
    int idx;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero();
    rstn = 0;

    for (int n = 0; n < 16; n++) cycle(1, gray(n), 1);
    idle(5, 1);

    cycle(1, gray(15), 1);
    cycle(1, gray(0), 1);
    idle(5, 1);

    cycle(1, 4'b0000, 1);
    cycle(1, 4'b0011, 1);
    idle(5, 1);
    check("illegal_count", err_count, CHK ? 1 : 0);
    for (int n = 0; n < 256; n++) cycle(1, n[0] ? 4'b0011 : 4'b0000, 1);
    idle(5, 1);
    check("sat_count", err_count, CHK ? 255 : 0);

    cycle(1, gray(1), 0);
    cycle(1, gray(2), 0);
    cycle(1, gray(3), 0);
    idle(4, 0);
    check("overflow_set", overflow, 1);
    check("held_head", binary_code, 1);
    idle(4, 1);

    cycle(1, gray(4), 0);
    cycle(1, gray(5), 0);
    cycle(1, gray(6), 0);
    idle(2, 0);
    idle(6, 1);

    cycle(1, gray(7), 0);
    cycle(1, gray(8), 0);
    idle(4, 0);
    check("pre_reset_full", binary_code_valid, 1);
    gray_code_valid = 0;
    #2 rstn = 1;
    #1 check_zero();
    model_reset();
    @(posedge clk);
    #1 rstn = 0;
    cycle(1, 4'b0011, 1);
    idle(4, 1);

    idx = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) idx = (idx + 1) % 16;
      else idx = $urandom_range(0, 15);
      cycle($urandom_range(0, 3) != 0, gray(idx), $urandom_range(0, 3) != 0);
    end
    idle(6, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
